rca_frame_accumulator: RTL
==========================

# rca_frame_accumulator

- Sequential stage wrapped around the 4-bit ripple-carry adder.
- Accepts a stream of 4-bit operands over a valid/ready handshake and adds each one into a running 4-bit partial sum.
- Counts adder carry-outs to widen that sum, and presents the full-width frame total downstream after every N_OPS operands.
- Sits directly on the adder: it drives one adder operand from the input stream and the other from its own accumulator, and consumes the adder's Sum/C4.

## Interface

Parameters:

- N_OPS, default 4: operands per frame. Must be ≥ 2.
- CW, default 2: width of the carry counter. Must satisfy 2^CW ≥ N_OPS.

Clock and reset: one clock; reset is asynchronous and active-low.

Ports:

- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous frame abort/clear.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts an operand this cycle.
- in_data  input  4  operand, unsigned.
- out_valid  output  1  frame result is valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  4  low 4 bits of the frame total.
- out_carries  output  CW  number of adder carry-outs in the frame.
- out_total  output  4+CW  equals {out_carries, out_sum}.
- op_count  output  CW  operands accepted so far in the current frame.

## Operation

- The adder is instantiated once, 4 bits wide, with carry-in tied to 0.
  - Operand A is acc[3:0]; operand B is in_data.
- FSM state ACCUM (the reset state):
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid&&in_ready.
  - On accept: acc ← adder Sum; carry_cnt ← carry_cnt + C4; op_count ← op_count+1.
  - The accept that brings op_count to N_OPS moves the FSM to DONE.
  - On that transition op_count wraps to 0. acc and carry_cnt hold the final values.
- FSM state DONE:
  - in_ready=0, out_valid=1.
  - out_sum/out_carries/out_total are held stable until the handshake.
  - Handshake occurs when out_valid&&out_ready. On handshake: acc←0, carry_cnt←0, FSM→ACCUM.
- Output mapping: out_sum=acc, out_carries=carry_cnt, out_total={carry_cnt,acc}. These outputs are registered and visible in both states.
- Arithmetic:
  - out_total is the exact unsigned sum of the N_OPS operands. The maximum is 15·N_OPS, which fits because 2^CW ≥ N_OPS.
  - carry_cnt never wraps within a legal configuration.
- clr:
  - Priority: rst_n > clr > handshake/accept.
  - When clr=1 in either state: acc, carry_cnt, op_count←0 and FSM→ACCUM. Any in_data or out handshake in that cycle is discarded.
- Reset (rst_n=0), effective immediately regardless of clk:
  - state=ACCUM, acc=0, carry_cnt=0, op_count=0.
  - Output values: out_valid=0, in_ready=1, out_sum=0, out_carries=0, out_total=0, op_count=0.
- Reset during a partial frame or in DONE discards the frame. No result is emitted.

## Timing

- in_ready and out_valid are pure decodes of the state register. There is no combinational path from in_valid/out_ready to any output.
- Accept latency: the updated acc/op_count are visible the cycle after the accept edge.
- Frame latency: out_valid rises the cycle after the N_OPS-th accept.
- Throughput: one operand per cycle in ACCUM. The frame costs N_OPS + (≥1 DONE cycle) cycles.
- A new operand is accepted at the earliest in the cycle after the output handshake. There is no input/output overlap.
- out_ready held 0: DONE persists indefinitely with outputs stable and in_ready=0 (backpressure).
- in_valid=0 in ACCUM: no state change; the frame pauses without limit.
- The adder's combinational path (4-bit ripple, 4 FA delays) plus the carry_cnt increment must close in one clk period.

## Test plan

- **Reset:** assert rst_n=0 mid-frame, asynchronously between edges. All outputs go to 0 immediately and in_ready=1. After release, frame 3,4,5,6 gives out_total=18 (out_sum=2, out_carries=1).
- **Max value:** frame 15,15,15,15 with no stalls. out_valid is asserted the cycle after the 4th accept, with out_sum=12, out_carries=3, out_total=60.
- **Backpressure:** frame 1,2,3,4 with out_ready=0 for 5 cycles. out_total=10 is held stable, in_ready=0, and in_valid pulses are ignored. After out_ready=1, a new frame 0,0,0,1 gives out_total=1.
- **Input stalls:** frame 8,8,8,8 with in_valid toggled 1,0,0,1,0,1,1. Only the accepts count: op_count steps 1,2,3 and then out_total=32 (out_sum=0, out_carries=2).
- **clr:** assert clr after 2 operands (7,9), simultaneously with in_valid=1. The frame restarts with op_count=0. Then 1,1,1,1 gives out_total=4. Also assert clr in DONE together with out_ready=1: out_valid drops and no extra frame is emitted.
- **Exhaustive pairs:** with N_OPS=2, CW=1, run all 256 pairs (a,b) back-to-back with out_ready=1. Every out_total equals a+b.

Source files
------------

// File: rtl/rca_frame_accumulator.sv
//==============================================================================
// rca_frame_accumulator
//   Valid/ready frame accumulator built on a 4-bit ripple-carry adder.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rca_frame_accumulator #(
  parameter int unsigned N_OPS = 4,
  parameter int unsigned CW    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_sum,
  output logic [CW-1:0]   out_carries,
  output logic [CW+3:0]   out_total,
  output logic [CW-1:0]   op_count
);

  localparam logic [0:0]  S_ACCUM     = 1'b0;
  localparam logic [0:0]  S_DONE      = 1'b1;
  localparam logic [CW:0] C_LAST_OP   = (CW+1)'(N_OPS);

  logic [0:0]    state_q, state_d;
  logic [3:0]    acc_q, acc_d;
  logic [CW-1:0] carry_cnt_q, carry_cnt_d;
  logic [CW-1:0] op_count_q, op_count_d;

  logic [3:0]    adder_sum;
  logic          adder_c4;
  logic [4:0]    adder_carry;
  logic [CW:0]   op_next;

  // Single 4-bit ripple-carry adder: A = accumulator, B = stream, Cin = 0.
  assign adder_carry[0] = 1'b0;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign adder_sum[i]     = acc_q[i] ^ in_data[i] ^ adder_carry[i];
    assign adder_carry[i+1] = (acc_q[i] & in_data[i]) |
                              (adder_carry[i] & (acc_q[i] ^ in_data[i]));
  end
  assign adder_c4 = adder_carry[4];

  // One extra bit so the comparison works when N_OPS == 2**CW.
  assign op_next = {1'b0, op_count_q} + (CW+1)'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_cnt_d = carry_cnt_q;
    op_count_d  = op_count_q;
    if (clr) begin
      state_d     = S_ACCUM;
      acc_d       = 4'd0;
      carry_cnt_d = '0;
      op_count_d  = '0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (in_valid) begin
            acc_d       = adder_sum;
            carry_cnt_d = carry_cnt_q + CW'(adder_c4);
            if (op_next == C_LAST_OP) begin
              op_count_d = '0;
              state_d    = S_DONE;
            end else begin
              op_count_d = op_next[CW-1:0];
            end
          end
        end
        default: begin
          if (out_ready) begin
            acc_d       = 4'd0;
            carry_cnt_d = '0;
            state_d     = S_ACCUM;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACCUM;
      acc_q       <= 4'd0;
      carry_cnt_q <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_cnt_q <= carry_cnt_d;
      op_count_q  <= op_count_d;
    end
  end

  assign in_ready    = (state_q == S_ACCUM);
  assign out_valid   = (state_q == S_DONE);
  assign out_sum     = acc_q;
  assign out_carries = carry_cnt_q;
  assign out_total   = {carry_cnt_q, acc_q};
  assign op_count    = op_count_q;

endmodule

`default_nettype wire
